// File: rtl/sbox_share_sched.sv
// Time-shares four AES sbox lanes between a 128-bit SubBytes state and a 32-bit SubWord key stream.
// The key word has priority and a 1-cycle latency. A state result takes 4-8 cycles, and a new state is taken only while idle.
module sbox_lane (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   logic [7:0] sq;
   logic [7:0] inv;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // The inverse is computed as x^254 = x^2 * x^4 * ... * x^128. This also maps 0 to 0.
   always_comb begin
      sq  = din;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module sbox_share_sched (
   input  logic         clk,
   input  logic         rst,
   input  logic         st_req_valid,
   output logic         st_req_ready,
   input  logic [127:0] st_req_data,
   output logic         st_rsp_valid,
   output logic [127:0] st_rsp_data,
   input  logic         kw_req_valid,
   output logic         kw_req_ready,
   input  logic [31:0]  kw_req_data,
   output logic         kw_rsp_valid,
   output logic [31:0]  kw_rsp_data,
   output logic         busy
);
   logic         st_active;
   logic [1:0]   cnt;
   logic [127:0] in_buf;
   logic [127:0] out_buf;
   logic         kw_last;
   logic         grant_kw;
   logic         st_beat;
   logic [31:0]  in_word;
   logic [31:0]  bank_in;
   logic [31:0]  bank_out;
   logic [127:0] out_next;

   // The key word yields exactly one slot after its own grant while a state is in flight, so the state cannot starve.
   assign grant_kw     = kw_req_valid & ~(st_active & kw_last);
   assign kw_req_ready = grant_kw;
   assign st_req_ready = ~st_active;
   assign st_beat      = st_active & ~grant_kw;
   assign busy         = st_active;

   always_comb begin
      in_word  = in_buf[127:96];
      out_next = out_buf;
      case (cnt)
         2'd0: begin in_word = in_buf[127:96]; out_next[127:96] = bank_out; end
         2'd1: begin in_word = in_buf[95:64];  out_next[95:64]  = bank_out; end
         2'd2: begin in_word = in_buf[63:32];  out_next[63:32]  = bank_out; end
         default: begin in_word = in_buf[31:0]; out_next[31:0] = bank_out; end
      endcase
      bank_in = grant_kw ? kw_req_data : in_word;
   end

   for (genvar g = 0; g < 4; g++) begin : g_lane
      sbox_lane u_lane (
         .din  (bank_in[8*g +: 8]),
         .dout (bank_out[8*g +: 8])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_active    <= 1'b0;
         cnt          <= 2'd0;
         in_buf       <= '0;
         out_buf      <= '0;
         kw_last      <= 1'b0;
         st_rsp_valid <= 1'b0;
         st_rsp_data  <= '0;
         kw_rsp_valid <= 1'b0;
         kw_rsp_data  <= '0;
      end else begin
         st_rsp_valid <= 1'b0;
         kw_rsp_valid <= 1'b0;
         kw_last      <= grant_kw;
         if (grant_kw) begin
            kw_rsp_valid <= 1'b1;
            kw_rsp_data  <= bank_out;
         end
         if (st_beat) begin
            out_buf <= out_next;
            cnt     <= cnt + 2'd1;
            if (cnt == 2'd3) begin
               st_active    <= 1'b0;
               st_rsp_valid <= 1'b1;
               st_rsp_data  <= out_next;
            end
         end else if (st_req_valid && st_req_ready) begin
            in_buf    <= st_req_data;
            cnt       <= 2'd0;
            st_active <= 1'b1;
         end
      end
   end
endmodule

// File: doc/sbox_share_sched.md
Name: sbox_share_sched

Overview:
Scheduler that time-shares one bank of 4 sbox instances (32 bits/cycle) between two requesters. The round datapath requests SubBytes on a 128-bit state, and key expansion requests SubWord on a 32-bit word. Key-word requests have priority. A fairness rule stops them from starving an in-flight state transform. The block sits between the round controller / key scheduler and the substitution logic, and instantiates the 4 sbox lanes internally.

Parameters:
none (lane count fixed at 4; state width fixed at 128)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
st_req_valid  in  1  state SubBytes request
st_req_ready  out  1  state request accepted when valid&ready at clk edge
st_req_data  in  128  state; word 0 = bits [127:96]
st_rsp_valid  out  1  one-cycle pulse, result valid; no backpressure
st_rsp_data  out  128  SubBytes(state), byte-wise
kw_req_valid  in  1  key-word SubWord request
kw_req_ready  out  1  grant (combinational)
kw_req_data  in  32  word
kw_rsp_valid  out  1  one-cycle pulse
kw_rsp_data  out  32  SubWord(word), byte-wise
busy  out  1  state transform in progress (st_active)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: st_rsp_valid=0, kw_rsp_valid=0, st_rsp_data=0, kw_rsp_data=0, busy=0. Internal: beat counter=0, kw_last=0, buffers=0.
- Registered state: st_active, beat cnt[1:0], in_buf[127:0], out_buf[127:0], kw_last (kw granted in previous cycle).
- Grant logic (combinational):
  - grant_kw = kw_req_valid & !(st_active & kw_last)
  - kw_req_ready = grant_kw
  - st_req_ready = !st_active (does not depend on kw)
  - st_beat = st_active & !grant_kw
- Sbox bank input mux: kw_req_data when grant_kw, else in_buf word cnt when st_beat, else don't-care. Lane i maps byte i to byte i.
- State accept: if st_req_valid & st_req_ready, then in_buf <= st_req_data, cnt <= 0, st_active <= 1. The accept cycle does not use the bank, so a kw grant may occur in the same cycle.
- State beat: out_buf word cnt <= sbox result, cnt <= cnt+1.
  - On the beat with cnt==3: st_active <= 0, st_rsp_valid <= 1, st_rsp_data <= the full result including the final word.
- kw service: if grant_kw, kw_rsp_valid <= 1 and kw_rsp_data <= sbox result at the next edge. Latency is 1 cycle.
- kw_last <= grant_kw every cycle.
- Both rsp_valid signals are high for exactly one cycle per completed request. st_rsp_data and kw_rsp_data hold their value until the next response.
- Latency:
  - State accepted at edge k, no kw contention: st_rsp_valid high after edge k+4.
  - kw held valid continuously during a state transform: grants alternate kw/beat, and the response comes after edge k+8.
  - Worst case is k+8.
- Throughput: st_req_ready is high in the cycle st_rsp_valid is asserted. Back-to-back blocks are accepted every 5 cycles without contention.
- When st_active=0, kw may be granted every cycle. Throughput is 1 word/cycle.
- Request data is sampled only at handshake and need not be held afterwards.
- Reset mid-operation: the in-flight transform is abandoned with no st_rsp_valid. The cycle after reset, st_req_ready=1.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all rsp outputs 0, busy=0, st_req_ready=1.
- Single state, no kw: data 00112233_44556677_8899aabb_ccddeeff accepted at edge k -> st_rsp_valid pulse after edge k+4, data 638293c3_1bfc33f5_c4eeacea_4bc12816. busy high for 4 cycles.
- Single kw while idle: kw_req_data=09cf4f3c -> kw_req_ready same cycle, kw_rsp_valid 1 cycle later with 018a84eb. A second word 00000053 the next cycle -> 636363ed the cycle after.
- Contention: accept the state above, then hold kw_req_valid (data 09cf4f3c) continuously ->
  - kw_req_ready alternates 1,0,1,0 while busy.
  - 4 kw responses, each 018a84eb.
  - st_rsp_valid after edge k+8 with correct data.
- Reset mid-op: assert rst after 2 beats of a state transform -> no st_rsp_valid. Next state 000...0 (all 00) accepted immediately -> 6363...63 after 4 cycles.
- Back-to-back: st_req_valid held with two blocks (all 01, then all ff) -> responses 7c7c..7c then 1616..16, spaced 5 cycles. The second block is accepted in the cycle the first response pulses.
